echo_mem_sequencer: RTL
=======================

# echo_mem_sequencer

Controller that runs the echo effect from the system clock, replacing per-echo delay-line memories with one shared single-port delay RAM. On each `note_sample_ready` strobe it writes the attenuated dry sample into the RAM, reads two delayed taps selected by `profile`, mixes them and presents a registered `note_sample_out` with a one-cycle `out_valid`. It sits between the note/sample generator and the codec output stage and owns the RAM's address, write-enable and write-data lines.

## Interface
- `WIDTH`, 16: sample width, two's complement.
- `ADDR_W`, 15: RAM address width; `DEPTH = 2**ADDR_W` entries.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `note_sample_in`  in  WIDTH  signed input sample, valid when `note_sample_ready`=1.
- `note_sample_ready`  in  1  one-cycle strobe, nominally 48 kHz.
- `profile`  in  2  echo profile, sampled on accepted strobe.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  WIDTH  RAM write data.
- `mem_rdata`  in  WIDTH  RAM read data, valid one cycle after the address is presented.
- `note_sample_out`  out  WIDTH  mixed output, held between updates.
- `out_valid`  out  1  one-cycle pulse when `note_sample_out` updates.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky; set when a strobe arrives while `busy`.

## Operation
- States: CLEAR, IDLE, WRITE, RD0, RD1, MIX.
- Reset (`rst`=1 on a clock edge; it has priority in every state): state←CLEAR, clear counter←0, wr_ptr←0, `note_sample_out`←0, `out_valid`←0, `overrun`←0. Reset in the middle of a sequence abandons that sequence and produces no `out_valid`.
- CLEAR: each cycle drives `mem_we`=1, `mem_addr`=clear counter, `mem_wdata`=0, then increments the counter. It moves to IDLE after writing address DEPTH−1, which takes DEPTH cycles. Strobes during CLEAR are ignored and do not set `overrun`.
- IDLE: `mem_we`=0. On a strobe, latch dry = `note_sample_in >>> 1` (arithmetic) and latch `profile`, then go to WRITE.
- WRITE: `mem_we`=1, `mem_addr`=wr_ptr, `mem_wdata`=dry. Go to RD0.
- RD0: `mem_addr`=wr_ptr − D0. Go to RD1.
- RD1: `mem_addr`=wr_ptr − D1. Capture `mem_rdata` as tap0. Go to MIX.
- MIX: use `mem_rdata` as tap1. Register `note_sample_out`=sat(dry + (tap0 >>> S0) + (tap1 >>> S1)). Set `out_valid` for the next cycle, increment wr_ptr, go to IDLE.
- Address subtraction is modulo DEPTH; it uses natural wrap at ADDR_W bits.
- Profiles (D = delay in samples, S = shift):
  - 00: D0=4800, S0=3; D1=9600, S1=4.
  - 01: D0=19200, S0=3; D1=24000, S1=4.
  - 10: D0=19200, S0=2; tap1 contributes 0.
  - 11: both taps contribute 0; output is dry only.
- Every read is still performed in every profile; a disabled tap is masked to 0 in the sum.
- Arithmetic: sign-extend each term to WIDTH+2 bits, sum them, then clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- wr_ptr wraps from DEPTH−1 to 0.
- Strobes while `busy` are dropped and set `overrun`; `overrun` stays set until reset.
- The stored value is the dry value, not the mix (no feedback).

## Timing
- Strobe accepted in cycle 0 (IDLE) → WRITE in cycle 1, RD0 in cycle 2, RD1 in cycle 3, MIX in cycle 4.
- `out_valid`=1 and the new `note_sample_out` appear in cycle 5, with the state back in IDLE. Latency is 5 cycles.
- The next strobe can be accepted in cycle 5.
- A strobe in the same cycle as `rst`=1 is ignored.
- `mem_we` is high only in CLEAR and WRITE.
- All outputs are registered except `mem_addr`, `mem_we` and `mem_wdata`, which decode the state.
- Minimum strobe spacing is 5 cycles; closer strobes set `overrun`.

## Test plan
- **Reset/clear:** assert `rst` 1 cycle, release → `busy`=1 for exactly 32768 cycles, `mem_we`=1 throughout, addresses 0..32767 in order, data 0; `note_sample_out`=0, `out_valid`=0.
- **Dry profile:** profile=11, input 0x4000 → `out_valid` 5 cycles after the strobe, output 0x2000. Input 0x8000 → 0xC000.
- **Profile 00 impulse:** 0x7FFE on strobe 0, zeros after → outputs 0x3FFF at sample 0, 0x07FF (0x3FFF>>>3) at sample 4800, 0x03FF (0x3FFF>>>4) at sample 9600, 0 elsewhere.
- **Profile 10 wrap:** run past 32768 strobes, then −32768 impulse → echo −4096 exactly 19200 samples later; the read address wraps correctly across 0.
- **Overrun:** second strobe 2 cycles after the first → exactly one `out_valid`, `overrun`=1, and it stays 1 until `rst`.
- **Reset mid-sequence:** `rst` in the RD0 cycle → no `out_valid`, CLEAR restarts at address 0, `note_sample_out`=0.

Source files
------------

// File: rtl/echo_mem_sequencer.sv
// echo_mem_sequencer: per-sample echo mixer that sequences one shared single-port delay RAM
// (clear sweep, dry write, two delayed tap reads, saturating mix).
module echo_mem_sequencer #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  note_sample_in,
   input  logic              note_sample_ready,
   input  logic [1:0]        profile,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [WIDTH-1:0]  note_sample_out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);
   typedef enum logic [2:0] {CLEAR, IDLE, WRITE, RD0, RD1, MIX} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] clr_q, clr_d, wr_ptr_q, wr_ptr_d, d0, d1;
   logic [WIDTH-1:0] dry_q, dry_d, tap0_q, tap0_d, out_q, out_d, mix;
   logic [1:0] prof_q, prof_d;
   logic out_valid_q, out_valid_d, overrun_q, overrun_d;
   logic signed [WIDTH-1:0] t0, t1;
   logic [WIDTH+1:0] sum;
   assign d0 = (prof_q == 2'b00) ? ADDR_W'(4800) : ADDR_W'(19200);
   assign d1 = (prof_q == 2'b00) ? ADDR_W'(9600) : ADDR_W'(24000);
   assign t0 = $signed(tap0_q) >>> ((prof_q == 2'b10) ? 2 : 3);
   assign t1 = $signed(mem_rdata) >>> 4;
   // Disabled taps are masked here; their reads still happen in every profile.
   assign sum = {{2{dry_q[WIDTH-1]}}, dry_q}
              + ((prof_q != 2'b11) ? {{2{t0[WIDTH-1]}}, t0} : '0)
              + (!prof_q[1] ? {{2{t1[WIDTH-1]}}, t1} : '0);
   assign mix = (sum[WIDTH+1:WIDTH-1] == 3'b000 || sum[WIDTH+1:WIDTH-1] == 3'b111) ? sum[WIDTH-1:0]
              : sum[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   always_comb begin
      state_d     = state_q;
      clr_d       = clr_q;
      wr_ptr_d    = wr_ptr_q;
      dry_d       = dry_q;
      prof_d      = prof_q;
      tap0_d      = tap0_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q | (note_sample_ready && state_q != IDLE && state_q != CLEAR);
      mem_we      = 1'b0;
      mem_addr    = wr_ptr_q;
      mem_wdata   = dry_q;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_q;
            mem_wdata = '0;
            clr_d     = clr_q + 1'b1;
            state_d   = (clr_q == '1) ? IDLE : CLEAR;
         end
         IDLE: if (note_sample_ready) begin
            dry_d   = $signed(note_sample_in) >>> 1;
            prof_d  = profile;
            state_d = WRITE;
         end
         WRITE: begin
            mem_we  = 1'b1;
            state_d = RD0;
         end
         RD0: begin
            mem_addr = wr_ptr_q - d0;
            state_d  = RD1;
         end
         RD1: begin
            mem_addr = wr_ptr_q - d1;
            tap0_d   = mem_rdata;
            state_d  = MIX;
         end
         MIX: begin
            out_d       = mix;
            out_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            state_d     = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         clr_q       <= '0;
         wr_ptr_q    <= '0;
         dry_q       <= '0;
         prof_q      <= '0;
         tap0_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         wr_ptr_q    <= wr_ptr_d;
         dry_q       <= dry_d;
         prof_q      <= prof_d;
         tap0_q      <= tap0_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end
   assign note_sample_out = out_q;
   assign out_valid       = out_valid_q;
   assign overrun         = overrun_q;
   assign busy            = state_q != IDLE;
endmodule
